// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the register file with pending-write scoreboard.
package mips_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_sb_if.sv
// Decode-stage bus for regfile_sb: read ports, writeback and issue/scoreboard signals.
interface regfile_sb_if
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     issue_ready;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    input  rd_data, rd_busy, issue_ready, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    output rd_data, rd_busy, issue_ready, busy_cnt
  );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: per-register busy bits, issue acceptance and busy count.
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ready,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  logic wr_hit;
  logic set_en;
  logic rise;
  logic fall;

  // A writeback to the same register frees the slot for a new issue in the same cycle.
  always_comb begin
    wr_hit      = wr_en && (wr_addr != ZERO);
    issue_ready = !busy[issue_addr] || (wr_en && (wr_addr == issue_addr)) || (issue_addr == ZERO);
    set_en      = issue_en && issue_ready && (issue_addr != ZERO);
    rise        = set_en && !busy[issue_addr];
    fall        = wr_hit && busy[wr_addr] && !(set_en && (issue_addr == wr_addr));
  end

  // Set is applied after clear so a same-register set/clear keeps the bit high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_hit) busy[wr_addr] <= 1'b0;
      if (set_en) busy[issue_addr] <= 1'b1;
      if (rise && !fall)
        busy_cnt <= busy_cnt + (ADDR_W+1)'(1);
      else if (fall && !rise)
        busy_cnt <= busy_cnt - (ADDR_W+1)'(1);
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with pending-write scoreboard; r0 is hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and busy clear to reads.
module regfile_sb
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);
  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO  = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (bus.wr_en),
    .wr_addr     (bus.wr_addr),
    .issue_en    (bus.issue_en),
    .issue_addr  (bus.issue_addr),
    .issue_ready (bus.issue_ready),
    .busy        (busy),
    .busy_cnt    (bus.busy_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.wr_en && (bus.wr_addr != ZERO)) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              byp;

    assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign byp = bus.wr_en && (bus.wr_addr == addr) && (addr != ZERO);
`else
    assign byp = 1'b0;
`endif
    // busy[0] can never be set, so r0 needs no special case on the busy path.
    assign bus.rd_data[k*DATA_W +: DATA_W] = (addr == ZERO) ? '0 :
                                             byp            ? bus.wr_data : mem[addr];
    assign bus.rd_busy[k] = busy[addr] && !byp;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard testbench for regfile_sb: directed hazards plus randomized traffic vs. an array model.
module tb_regfile_sb;
  import mips_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 3;

  typedef struct packed {
    int                       id;
    logic [NUM_RD*DATA_W-1:0] data;
    logic [NUM_RD-1:0]        busy;
    logic                     ready;
    logic [ADDR_W:0]          cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   chk_id;
  exp_t exp_q[$];

  logic [DATA_W-1:0] m_regs [32];
  bit                m_pend [32];
  reg_addr_t         cur_ra [NUM_RD];
  logic              cur_we;
  reg_addr_t         cur_wa;
  logic [DATA_W-1:0] cur_wd;
  reg_addr_t         cur_ia;

  regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs straight from the architectural rules applied to the model arrays.
  function automatic exp_t modelExpect();
    exp_t e;
    int   c;
    logic [DATA_W-1:0] d;
    logic b;
    e = '0;
    e.id = chk_id;
    for (int k = 0; k < NUM_RD; k++) begin
      if (cur_ra[k] == 0) begin
        d = '0;
        b = 1'b0;
      end else begin
        d = m_regs[cur_ra[k]];
        b = m_pend[cur_ra[k]];
`ifdef REGFILE_BYPASS_EN
        if (cur_we && cur_wa == cur_ra[k]) begin
          d = cur_wd;
          b = 1'b0;
        end
`endif
      end
      e.data[k*DATA_W +: DATA_W] = d;
      e.busy[k] = b;
    end
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    e.cnt   = (ADDR_W+1)'(c);
    e.ready = (cur_ia == 0) || !m_pend[cur_ia] || (cur_we && cur_wa == cur_ia);
    return e;
  endfunction

  task automatic applyStimulus(input reg_addr_t a0, input reg_addr_t a1, input reg_addr_t a2,
                               input logic we, input reg_addr_t wa, input logic [DATA_W-1:0] wd,
                               input logic ie, input reg_addr_t ia);
    exp_t e;
    @(posedge clk);
    #1;
    cur_ra[0] = a0; cur_ra[1] = a1; cur_ra[2] = a2;
    cur_we = we; cur_wa = wa; cur_wd = wd; cur_ia = ia;
    bus.rd_addr    = {a2, a1, a0};
    bus.wr_en      = we;
    bus.wr_addr    = wa;
    bus.wr_data    = wd;
    bus.issue_en   = ie;
    bus.issue_addr = ia;
    chk_id++;
    e = modelExpect();
    exp_q.push_back(e);
    if (we && wa != 0) begin
      m_regs[wa] = wd;
      m_pend[wa] = 1'b0;
    end
    if (ie && e.ready && ia != 0) m_pend[ia] = 1'b1;
  endtask

  task automatic idleRead(input reg_addr_t a0, input reg_addr_t a1, input reg_addr_t a2);
    applyStimulus(a0, a1, a2, 1'b0, 5'd0, '0, 1'b0, 5'd0);
  endtask

  // Reset is checked during the low phase, before any clock edge can act on it.
  task automatic doReset(input reg_addr_t a0, input reg_addr_t a1, input reg_addr_t a2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    cur_ra[0] = a0; cur_ra[1] = a1; cur_ra[2] = a2;
    cur_we = 1'b0; cur_wa = '0; cur_wd = '0; cur_ia = '0;
    bus.rd_addr = {a2, a1, a0};
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.issue_en = 1'b0; bus.issue_addr = '0;
    chk_id++;
    exp_q.push_back(modelExpect());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic checkOutput(input exp_t e);
    tests++;
    if (bus.rd_data !== e.data) begin
      fails++;
      $display("[TB] FAIL rd_data chk%0d: got %h, expected %h", e.id, bus.rd_data, e.data);
    end
    tests++;
    if (bus.rd_busy !== e.busy) begin
      fails++;
      $display("[TB] FAIL rd_busy chk%0d: got %b, expected %b", e.id, bus.rd_busy, e.busy);
    end
    tests++;
    if (bus.issue_ready !== e.ready) begin
      fails++;
      $display("[TB] FAIL issue_ready chk%0d: got %b, expected %b", e.id, bus.issue_ready, e.ready);
    end
    tests++;
    if (bus.busy_cnt !== e.cnt) begin
      fails++;
      $display("[TB] FAIL busy_cnt chk%0d: got %0d, expected %0d", e.id, bus.busy_cnt, e.cnt);
    end
  endtask

  // Monitor: compares whatever the driver queued for this cycle, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    chk_id = 0;
    rst_n = 1'b0;
    bus.rd_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.issue_en = 1'b0; bus.issue_addr = '0;
    doReset(5'd5, 5'd7, 5'd0);

    // Mid-operation reset discards data and pending state.
    applyStimulus(5'd5, 5'd7, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd7);
    idleRead(5'd5, 5'd7, 5'd0);
    doReset(5'd5, 5'd7, 5'd5);

    // Register 0: writes dropped, issue accepted without marking busy.
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0);
    idleRead(5'd0, 5'd0, 5'd0);

    // Scoreboard round trip on r3.
    applyStimulus(5'd3, 5'd0, 5'd3, 1'b0, 5'd0, '0, 1'b1, 5'd3);
    idleRead(5'd3, 5'd0, 5'd3);
    applyStimulus(5'd3, 5'd0, 5'd3, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0);
    idleRead(5'd3, 5'd0, 5'd3);

    // WAW refusal, then re-issue accepted alongside the writeback.
    applyStimulus(5'd4, 5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b1, 5'd4);
    applyStimulus(5'd4, 5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b1, 5'd4);
    applyStimulus(5'd4, 5'd0, 5'd0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4);
    idleRead(5'd4, 5'd0, 5'd0);

    // Multi-port reads of shared addresses.
    applyStimulus(5'd1, 5'd2, 5'd1, 1'b1, 5'd1, 32'h11, 1'b0, 5'd0);
    applyStimulus(5'd1, 5'd2, 5'd1, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0);
    idleRead(5'd1, 5'd2, 5'd1);

    // Same-cycle write/read of a pending register (forwarding behaviour).
    applyStimulus(5'd9, 5'd9, 5'd0, 1'b0, 5'd0, '0, 1'b1, 5'd9);
    applyStimulus(5'd9, 5'd9, 5'd0, 1'b1, 5'd9, 32'hA5A5, 1'b0, 5'd0);
    idleRead(5'd9, 5'd9, 5'd0);

    // Fill the scoreboard to its ceiling of 31, then issue r0 at full count.
    for (int r = 1; r < 32; r++)
      applyStimulus(reg_addr_t'(r), 5'd0, 5'd31, 1'b0, 5'd0, '0, 1'b1, reg_addr_t'(r));
    applyStimulus(5'd31, 5'd1, 5'd0, 1'b0, 5'd0, '0, 1'b1, 5'd0);
    applyStimulus(5'd31, 5'd1, 5'd0, 1'b1, 5'd17, 32'h17, 1'b1, 5'd5);
    idleRead(5'd17, 5'd5, 5'd0);
    doReset(5'd17, 5'd31, 5'd1);

    // Randomized traffic over a narrow address range to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(reg_addr_t'($urandom_range(0, 7)), reg_addr_t'($urandom_range(0, 7)),
                    reg_addr_t'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), reg_addr_t'($urandom_range(0, 7)), $urandom(),
                    1'($urandom_range(0, 1)), reg_addr_t'($urandom_range(0, 7)));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the single-issue register set: N read ports, configurable width and depth, and a per-register pending-write scoreboard.
- Sits in the decode stage of the pipelined core.
- Decode issues a destination to mark it pending; writeback clears it.
- Hazard logic uses the busy outputs to stall dependent instructions.

Parameters:
- DATA_W, 32, register data width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- RD_ADDR  input  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- RD_DATA  output  NUM_RD*DATA_W  packed read data, same packing
- RD_BUSY  output  NUM_RD  per-port flag: addressed register has a pending write
- WR_EN  input  1  writeback strobe
- WR_ADDR  input  ADDR_W  writeback destination
- WR_DATA  input  DATA_W  writeback data
- ISSUE_EN  input  1  request to mark ISSUE_ADDR pending
- ISSUE_ADDR  input  ADDR_W  destination of the issuing instruction
- ISSUE_READY  output  1  issue is accepted this cycle
- BUSY_CNT  output  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (RST_N low, asynchronous):
  - all registers cleared to 0; all busy bits cleared to 0; BUSY_CNT = 0.
  - Outputs follow combinationally: RD_DATA = 0, RD_BUSY = 0, ISSUE_READY = 1 (when ISSUE_ADDR is not busy).
  - Reset asserted mid-operation discards all pending state immediately.
- Register 0:
  - always reads 0 and is never busy.
  - Writes to 0 are ignored.
  - An issue to 0 is accepted (ISSUE_READY = 1) but sets no busy bit and does not change BUSY_CNT.
- Reads: combinational, zero latency, all ports independent. Any ports may share an address.
- Writes: on the rising CLK edge with WR_EN = 1 and WR_ADDR != 0, reg[WR_ADDR] <= WR_DATA.
  - A write clears busy[WR_ADDR].
  - A write to a non-busy register is legal: data is committed, busy is unchanged.
- Issue acceptance:
  - ISSUE_READY = !busy[ISSUE_ADDR] || (WR_EN && WR_ADDR == ISSUE_ADDR) || ISSUE_ADDR == 0.
  - An issue is accepted when ISSUE_EN && ISSUE_READY; on the next edge busy[ISSUE_ADDR] <= 1.
  - An issue to a register that is already busy (WAW) is refused (ISSUE_READY = 0) unless that register is being written back in the same cycle.
- Simultaneous write and issue to the same nonzero register: set has priority.
  - The register receives WR_DATA, busy stays 1, BUSY_CNT is unchanged.
- BUSY_CNT update per edge: +1 for a set-only transition, -1 for a clear-only transition, unchanged otherwise.
  - Width ADDR_W+1, so it never wraps.
  - BUSY_CNT max = 2**ADDR_W - 1, because register 0 is never busy.
- Read/write same cycle, same nonzero address: governed by the optional feature below.
- All decisions use registered state plus current-cycle inputs only. No internal pipeline, no multi-cycle latency.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - RD_DATA[k] = WR_DATA when WR_EN && WR_ADDR == RD_ADDR[k] != 0.
  - RD_BUSY[k] = 0 in the same condition (write-through for data and busy).
- Undefined:
  - reads return the stored value and stored busy bit.
  - The written value and the cleared busy bit become visible the cycle after the write.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W_DEF = 32, ADDR_W_DEF = 5
  - ZERO_REG = 0
  - a typedef for the register-address type
- One sub-module: regfile_scoreboard.
  - Contains the busy-bit vector, the ISSUE_READY logic and BUSY_CNT.
  - Inputs: WR_EN/WR_ADDR and ISSUE_EN/ISSUE_ADDR.
- Storage array and read muxing stay in regfile_sb.

Test Plan:
- Reset:
  - Stimulus: assert RST_N low mid-test after writing 0xDEADBEEF to r5 and issuing r7; release reset.
  - Required response: RD_DATA for r5 = 0, RD_BUSY for r7 = 0, BUSY_CNT = 0, no clock edge required.
- Register 0:
  - Stimulus: write 0x1234 to r0; issue r0.
  - Required response: reads of r0 return 0, ISSUE_READY = 1, BUSY_CNT stays 0.
- Scoreboard round trip:
  - Stimulus: issue r3, then write 0x55 to r3 two cycles later.
  - Required response: RD_BUSY on r3 = 1 for two cycles, then 0; BUSY_CNT goes 0 -> 1 -> 0; r3 reads 0x55.
- WAW refusal and simultaneous set/clear:
  - Stimulus: issue r4, then re-issue r4 with no write.
  - Required response: ISSUE_READY = 0, BUSY_CNT = 1.
  - Stimulus: re-issue r4 in the same cycle as WR_EN to r4.
  - Required response: ISSUE_READY = 1, busy stays 1, BUSY_CNT stays 1.
- Multi-port:
  - Setup: NUM_RD = 3, r1 = 0x11, r2 = 0x22.
  - Stimulus: read r1, r2, r1 simultaneously.
  - Required response: packed RD_DATA = {0x11, 0x22, 0x11}.
- Bypass:
  - Stimulus: WR_EN to r9 with 0xA5A5 while reading r9 in the same cycle.
  - With REGFILE_BYPASS_EN: RD_DATA = 0xA5A5 and RD_BUSY = 0 in that cycle.
  - Without REGFILE_BYPASS_EN: the old value is returned; 0xA5A5 appears the next cycle.
